deck_ctrl: RTL and testbench

DECK_CTRL -- requirements
Module: deck_ctrl

---
 rtl/deck_pkg.sv | 29 ++
 rtl/deck_lfsr.sv | 25 ++
 rtl/deck_ctrl.sv | 130 +++++++++++++
 tb/tb_deck_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/deck_pkg.sv
// Shared types and helpers for the card deck controller.
// Holds the FSM state enum, deck geometry and the blackjack value lookup.
package deck_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_SEEK  = 2'd1,
    S_READY = 2'd2,
    S_EMPTY = 2'd3
  } deck_state_t;

  localparam int DECK_SIZE  = 52;
  localparam int RANK_COUNT = 13;
  localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

  // Ace counts 11, pips count face value, picture cards count 10.
  function automatic logic [4:0] card_value(input logic [5:0] idx);
    logic [5:0] rank;
    rank = idx % 6'(RANK_COUNT);
    if (rank == 6'd0) begin
      return 5'd11;
    end else if (rank <= 6'd9) begin
      return 5'(rank + 6'd1);
    end else begin
      return 5'd10;
    end
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Loads SEED while RST is high and steps once per clock otherwise.
module deck_lfsr (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SEED,
  output logic [7:0] Q
);

  logic [7:0] q_reg;
  logic       feedback;

  assign feedback = q_reg[7] ^ q_reg[5] ^ q_reg[4] ^ q_reg[3];

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= SEED;
    end else begin
      q_reg <= {q_reg[6:0], feedback};
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/deck_ctrl.sv
// 52-card deck dealer: presents one undealt card at a time and marks it used on REQ.
// Define DECK_RANDOM_EN to pick the next search start from an LFSR instead of dealing in order.
module deck_ctrl
  import deck_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hB4,
  parameter logic [5:0] LOW_WATER = 6'd10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SHUFFLE,
  input  logic       REQ,
  output logic       RDY,
  output logic [5:0] CARD_IDX,
  output logic [4:0] CARD_VAL,
  output logic [5:0] CARDS_LEFT,
  output logic       EMPTY,
  output logic       LOW
);

  deck_state_t          state_reg, state_next;
  logic [DECK_SIZE-1:0] mask_reg, mask_next;
  logic [5:0]           cand_reg, cand_next;
  logic [5:0]           left_reg, left_next;
  logic [5:0]           idx_reg, idx_next;
  logic [5:0]           cand_after_accept;
  logic                 accept;
  logic                 mask_clear;
  logic                 cand_free;

`ifdef DECK_RANDOM_EN
  logic [7:0] lfsr_q;
  logic [5:0] lfsr_low;
  logic       unused_lfsr;

  deck_lfsr u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .SEED (LFSR_SEED),
    .Q    (lfsr_q)
  );

  assign lfsr_low    = lfsr_q[5:0];
  assign unused_lfsr = ^lfsr_q[7:6];
  // Fold 52..63 back into the deck so every start point is a legal index.
  assign cand_after_accept = (lfsr_low >= 6'(DECK_SIZE)) ? lfsr_low - 6'(DECK_SIZE) : lfsr_low;
`else
  logic unused_seed;

  assign unused_seed       = ^LFSR_SEED;
  assign cand_after_accept = (idx_reg == LAST_IDX) ? 6'd0 : idx_reg + 6'd1;
`endif

  assign cand_free  = ~mask_reg[cand_reg];
  assign accept     = (state_reg == S_READY) && REQ && !SHUFFLE;
  assign mask_clear = (state_reg == S_CLEAR);

  genvar gi;
  generate
    for (gi = 0; gi < DECK_SIZE; gi++) begin : g_mask
      assign mask_next[gi] = mask_clear ? 1'b0 :
                             (accept && (idx_reg == 6'(gi))) ? 1'b1 : mask_reg[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_CLEAR;
      mask_reg  <= '0;
      cand_reg  <= 6'd0;
      left_reg  <= 6'(DECK_SIZE);
      idx_reg   <= 6'd0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      cand_reg  <= cand_next;
      left_reg  <= left_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    left_next  = left_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_CLEAR: begin
        left_next  = 6'(DECK_SIZE);
        cand_next  = 6'd0;
        state_next = S_SEEK;
      end
      S_SEEK: begin
        if (cand_free) begin
          idx_next   = cand_reg;
          state_next = S_READY;
        end else begin
          cand_next = (cand_reg == LAST_IDX) ? 6'd0 : cand_reg + 6'd1;
        end
      end
      S_READY: begin
        if (accept) begin
          left_next  = left_reg - 6'd1;
          cand_next  = cand_after_accept;
          state_next = (left_reg == 6'd1) ? S_EMPTY : S_SEEK;
        end
      end
      S_EMPTY: begin
        state_next = S_EMPTY;
      end
      default: begin
        state_next = S_CLEAR;
      end
    endcase
    // A shuffle wins over everything but reset, including a same-cycle accept.
    if (SHUFFLE) begin
      state_next = S_CLEAR;
    end
  end

  always_comb begin
    RDY        = (state_reg == S_READY);
    EMPTY      = (state_reg == S_EMPTY);
    CARD_IDX   = idx_reg;
    CARD_VAL   = card_value(idx_reg);
    CARDS_LEFT = left_reg;
    LOW        = (left_reg <= LOW_WATER);
  end

endmodule

// File: tb/tb_deck_ctrl.sv
// Randomized self-checking bench for deck_ctrl against a deck-level reference model.
// Works in the default build and with DECK_RANDOM_EN defined.
module tb_deck_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SHUFFLE;
  logic       REQ;
  logic       RDY;
  logic [5:0] CARD_IDX;
  logic [4:0] CARD_VAL;
  logic [5:0] CARDS_LEFT;
  logic       EMPTY;
  logic       LOW;

  deck_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .SHUFFLE    (SHUFFLE),
    .REQ        (REQ),
    .RDY        (RDY),
    .CARD_IDX   (CARD_IDX),
    .CARD_VAL   (CARD_VAL),
    .CARDS_LEFT (CARDS_LEFT),
    .EMPTY      (EMPTY),
    .LOW        (LOW)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference deck: which cards are gone, how many remain, what comes next.
  bit used [52];
  int left;
  int exp_idx;
  int wait_cnt;
  int gap;
  bit in_clear;
  bit is_empty;
  bit rnd_seek;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_value(input int idx);
    int r;
    r = idx % 13;
    if (r == 0) return 11;
    if (r < 10) return r + 1;
    return 10;
  endfunction

  task automatic model_restart(input bit from_rst);
    if (from_rst || in_clear) left = 52;
    foreach (used[i]) used[i] = 1'b0;
    is_empty = 1'b0;
    wait_cnt = 2;
    in_clear = 1'b1;
    exp_idx  = 0;
    rnd_seek = 1'b0;
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle(input bit rst, input bit shuf, input bit req_in);
    bit exp_rdy;
    bit acc;
    int nxt;
    int skips;
    @(negedge CLK);
    check_val("cards_left", CARDS_LEFT, left);
    check_val("low", LOW, (left <= 10));
    check_val("empty", EMPTY, is_empty);
    exp_rdy = 1'b0;
    if (is_empty || wait_cnt > 0) begin
      check_val("rdy_low", RDY, 0);
      if (wait_cnt > 0) wait_cnt--;
    end else if (rnd_seek) begin
      if (RDY === 1'b1) begin
        check_val("idx_range", (CARD_IDX < 6'd52), 1);
        if (CARD_IDX < 6'd52) check_val("idx_fresh", used[CARD_IDX], 0);
        check_val("card_val", CARD_VAL, ref_value(int'(CARD_IDX)));
        exp_idx  = int'(CARD_IDX) % 52;
        rnd_seek = 1'b0;
        exp_rdy  = 1'b1;
      end else begin
        gap++;
        check_val("rdy_gap", (gap <= 53), 1);
      end
    end else begin
      exp_rdy = 1'b1;
      check_val("rdy", RDY, 1);
      check_val("card_idx", CARD_IDX, exp_idx);
      check_val("card_val", CARD_VAL, ref_value(exp_idx));
    end

    acc = req_in && exp_rdy && !rst && !shuf;
    if (rst || shuf) begin
      model_restart(rst);
    end else begin
      if (in_clear) left = 52;
      in_clear = 1'b0;
      if (acc) begin
        $display("deal idx=%0d val=%0d left_after=%0d", exp_idx, ref_value(exp_idx), left - 1);
        used[exp_idx] = 1'b1;
        left--;
        if (left == 0) begin
          is_empty = 1'b1;
        end else begin
`ifdef DECK_RANDOM_EN
          rnd_seek = 1'b1;
          gap      = 0;
`else
          nxt   = (exp_idx + 1) % 52;
          skips = 0;
          while (used[nxt]) begin
            nxt = (nxt + 1) % 52;
            skips++;
          end
          exp_idx  = nxt;
          wait_cnt = 1 + skips;
`endif
        end
      end
    end
    RST     = rst;
    SHUFFLE = shuf;
    REQ     = req_in;
  endtask

  task automatic run_until_left(input int target);
    for (int k = 0; k < 300 && left != target; k++) cycle(1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    check_val("reach_left", CARDS_LEFT, target);
  endtask

  initial begin
    int r;
    RST     = 1'b1;
    SHUFFLE = 1'b0;
    REQ     = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_idx", CARD_IDX, 0);
    check_val("rst_rdy", RDY, 0);
    in_clear = 1'b1;
    model_restart(1'b1);

    // Release reset; ready two edges later with card 0.
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Deal the whole deck, then poke the empty deck and reshuffle.
    run_until_left(39);
    check_val("low_at_39", LOW, 0);
    run_until_left(0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    // Shuffle together with REQ while a card is presented at 40 left.
    run_until_left(40);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    // Reset pulsed mid-seek at 20 left.
    run_until_left(20);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_val("rst_mid_idx", CARD_IDX, 0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Random traffic with occasional shuffles and resets.
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 999));
      cycle(r < 2, (r >= 2) && (r < 5), $urandom_range(0, 99) < 65);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
